// File: rtl/audio_pkg.sv
// Shared audio definitions for the PWM sink and the BRAM players that feed it.
//   audio_sample_t  : 8-bit unsigned sample, AUDIO_MIDSCALE is silence
//   pwm_state_t     : soft start/stop sequencer states
//   step_toward     : moves a level one code toward a target (ramp helper)
package audio_pkg;

  typedef logic [7:0] audio_sample_t;

  localparam audio_sample_t AUDIO_MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } pwm_state_t;

  function automatic audio_sample_t step_toward(input audio_sample_t cur,
                                                input audio_sample_t tgt);
    audio_sample_t res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_pwm_modulator.sv
// Single-bit PWM carrier generator.
// Ports:
//   CLK, RESET_N : clock, asynchronous active-low reset
//   duty_next    : duty to adopt at the next period boundary
//   clear        : forces the duty register and carrier low
//   pwm_out      : registered carrier, high while counter < duty
//   period_end   : high on the last cycle of each 256-cycle period
module audio_pwm_modulator
  import audio_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] duty_next,
  input  logic       clear,
  output logic       pwm_out,
  output logic       period_end
);

  logic [7:0]    cnt_q, cnt_d;
  audio_sample_t duty_q, duty_d;
  logic          pwm_q, pwm_d;

  assign period_end = (cnt_q == 8'hFF);

  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    duty_d = duty_q;
    pwm_d  = (cnt_q < duty_q);
    // Duty only changes on the wrap so a period is never split.
    if (period_end) begin
      duty_d = duty_next;
    end
    if (clear) begin
      duty_d = '0;
      pwm_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/audio_pwm_sink.sv
// Consumer of the 8-bit sample_tick audio stream: latches samples, drives the
// PWM carrier to the mono filter/amplifier, sequences the amplifier shutdown
// pin and substitutes midscale silence when the stream stalls.
// Optional feature macro: AUDIO_PWM_SOFT_RAMP_EN (soft start/stop ramps).
// Ports:
//   CLK, RESET_N     : clock, asynchronous active-low reset
//   enable           : 1 = play, 0 = silence and shut down
//   audio_sample_in  : unsigned sample, 0x80 = silence
//   sample_tick      : one-cycle strobe qualifying audio_sample_in
//   pwm_out          : registered PWM carrier
//   amp_sd_n         : amplifier enable (0 = shutdown)
//   underrun         : one-cycle pulse when the watchdog expires
//   playing          : high only in PLAY
module audio_pwm_sink
  import audio_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned SAMPLE_RATE_HZ  = 16_000,
  parameter int unsigned WATCHDOG_CYCLES = 2 * (CLK_FREQ_HZ / SAMPLE_RATE_HZ),
  parameter int unsigned RAMP_DIV        = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       enable,
  input  logic [7:0] audio_sample_in,
  input  logic       sample_tick,
  output logic       pwm_out,
  output logic       amp_sd_n,
  output logic       underrun,
  output logic       playing
);

  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  if (WATCHDOG_CYCLES < 2) begin : g_bad_watchdog
    $error("WATCHDOG_CYCLES must be at least 2");
  end
  if (RAMP_DIV < 1) begin : g_bad_ramp_div
    $error("RAMP_DIV must be at least 1");
  end
  if (SAMPLE_RATE_HZ == 0) begin : g_bad_rate
    $error("SAMPLE_RATE_HZ must be non-zero");
  end

  pwm_state_t      state_q, state_d;
  audio_sample_t   sample_q, sample_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            underrun_q, underrun_d;
  logic            amp_q, amp_d;
  logic            playing_q, playing_d;
  audio_sample_t   duty_next;
  logic            period_end;

  // Sample capture and underrun watchdog. A tick always wins over expiry.
  always_comb begin
    sample_d   = sample_q;
    wd_d       = wd_q;
    underrun_d = 1'b0;
    if (sample_tick) begin
      sample_d = audio_sample_in;
      wd_d     = '0;
    end else if (state_q != PLAY) begin
      wd_d = '0;
    end else if (wd_q == WD_LAST) begin
      sample_d   = AUDIO_MIDSCALE;
      wd_d       = '0;
      underrun_d = 1'b1;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

`ifdef AUDIO_PWM_SOFT_RAMP_EN
  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  audio_sample_t  level_q, level_d;
  logic [DIV_W-1:0] div_q, div_d;
  // Copy of the duty currently being modulated; becomes the ramp-down start.
  audio_sample_t  duty_cur_q, duty_cur_d;
  logic           ramp_step;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    div_d      = div_q;
    duty_cur_d = duty_cur_q;
    ramp_step  = period_end && (div_q == DIV_LAST);
    if (period_end) begin
      duty_cur_d = duty_next;
      div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    unique case (state_q)
      OFF: begin
        if (enable) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
        end else if (level_q == AUDIO_MIDSCALE) begin
          state_d = PLAY;
          level_d = sample_q;
        end else if (ramp_step) begin
          // A reversed ramp may start above midscale and must walk down.
          level_d = step_toward(level_q, AUDIO_MIDSCALE);
        end
      end
      PLAY: begin
        if (!enable) begin
          state_d = RAMP_DOWN;
          level_d = duty_cur_q;
        end
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_d = RAMP_UP;
        end else if (level_q == '0) begin
          state_d = OFF;
        end else if (ramp_step) begin
          level_d = level_q - 8'd1;
        end
      end
      default: state_d = OFF;
    endcase
    if (state_d != state_q) begin
      div_d = '0;
    end
  end

  always_comb begin
    unique case (state_q)
      PLAY:              duty_next = sample_q;
      RAMP_UP, RAMP_DOWN: duty_next = level_q;
      default:           duty_next = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      level_q    <= '0;
      div_q      <= '0;
      duty_cur_q <= '0;
    end else begin
      level_q    <= level_d;
      div_q      <= div_d;
      duty_cur_q <= duty_cur_d;
    end
  end
`else
  // Without ramps the carrier switches straight between silence and samples.
  logic unused_period_end;
  assign unused_period_end = period_end;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:     if (enable)  state_d = PLAY;
      PLAY:    if (!enable) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  assign duty_next = (state_q == PLAY) ? sample_q : '0;
`endif

  // Status outputs are decoded from the next state so they line up with it.
  always_comb begin
    amp_d     = (state_d != OFF);
    playing_d = (state_d == PLAY);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= OFF;
      sample_q   <= AUDIO_MIDSCALE;
      wd_q       <= '0;
      underrun_q <= 1'b0;
      amp_q      <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      wd_q       <= wd_d;
      underrun_q <= underrun_d;
      amp_q      <= amp_d;
      playing_q  <= playing_d;
    end
  end

  audio_pwm_modulator u_mod (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .duty_next  (duty_next),
    .clear      (state_q == OFF),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  assign amp_sd_n = amp_q;
  assign underrun = underrun_q;
  assign playing  = playing_q;

endmodule

// File: tb/tb_audio_pwm_sink.sv
module tb_audio_pwm_sink;
  import audio_pkg::*;

  localparam int unsigned WD   = 3000;
  localparam int unsigned RDIV = 1;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] audio_sample_in = 8'h00;
  logic       sample_tick = 1'b0;
  logic       pwm_out, amp_sd_n, underrun, playing;

  int checks = 0;
  int errors = 0;

  audio_pwm_sink #(
    .CLK_FREQ_HZ     (100_000_000),
    .SAMPLE_RATE_HZ  (16_000),
    .WATCHDOG_CYCLES (WD),
    .RAMP_DIV        (RDIV)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .enable          (enable),
    .audio_sample_in (audio_sample_in),
    .sample_tick     (sample_tick),
    .pwm_out         (pwm_out),
    .amp_sd_n        (amp_sd_n),
    .underrun        (underrun),
    .playing         (playing)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Index of the next active edge since reset release.
  int unsigned edge_cnt = 0;
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  typedef struct packed {
    logic [31:0] win;
    logic [31:0] hi;
  } exp_t;
  exp_t sb[$];

  // Window w covers edges 256w..256w+255; its duty is loaded at edge 256w-1.
  function automatic int unsigned win_after(input int unsigned n);
    int unsigned r;
    r = (n / 256) * 256 + 255;
    if (r <= n) r += 256;
    return (r + 1) / 256;
  endfunction

  task automatic expect_duty(input int unsigned n, input int unsigned d);
    exp_t e;
    e.win = win_after(n);
    e.hi  = d;
    sb.push_back(e);
  endtask

  bit          mon_en = 0;
  bit          mono_en = 0;
  int unsigned mono_bad = 0;

  initial begin : monitor
    int unsigned j, w, hi_cnt, last_hi;
    hi_cnt = 0;
    last_hi = 0;
    forever begin
      @(negedge CLK);
      if (mon_en && RESET_N && edge_cnt > 0) begin
        j = edge_cnt - 1;
        if (j % 256 == 0) hi_cnt = 0;
        if (pwm_out) hi_cnt++;
        if (j % 256 == 255) begin
          w = j / 256;
          while (sb.size() > 0 && sb[0].win < w) begin
            check_eq("duty_window_missed", sb[0].win, w);
            void'(sb.pop_front());
          end
          if (sb.size() > 0 && sb[0].win == w) begin
            check_eq("period_high_cycles", hi_cnt, sb[0].hi);
            void'(sb.pop_front());
          end
          if (mono_en) begin
            if (hi_cnt < last_hi) mono_bad++;
            last_hi = hi_cnt;
          end
        end
      end
    end
  end

  task automatic tick(input logic [7:0] v, output int unsigned n);
    n = edge_cnt;
    audio_sample_in = v;
    sample_tick = 1'b1;
    @(negedge CLK);
    sample_tick = 1'b0;
  endtask

  task automatic wait_windows(input int unsigned k);
    repeat (k * 256) @(negedge CLK);
  endtask

  initial begin : main
    int unsigned n, e, bad, pulses, last;
    bit seen;

    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_pwm_out", pwm_out, 0);
    check_eq("rst_amp_sd_n", amp_sd_n, 0);
    check_eq("rst_playing", playing, 0);
    check_eq("rst_underrun", underrun, 0);
    RESET_N = 1'b1;
    mon_en = 1'b1;

    bad = 0;
    repeat (10000) begin
      @(negedge CLK);
      if (pwm_out || amp_sd_n || playing || underrun) bad++;
    end
    check_eq("idle_active_cycles", bad, 0);

`ifdef AUDIO_PWM_SOFT_RAMP_EN
    n = edge_cnt;
    enable = 1'b1;
    @(negedge CLK);
    check_eq("ramp_amp_on_next", amp_sd_n, 1);
    check_eq("ramp_not_playing", playing, 0);
    mono_en = 1'b1;
    seen = 0;
    e = 0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(negedge CLK);
      if (playing) begin
        seen = 1;
        e = edge_cnt - 1;
      end
    end
    mono_en = 1'b0;
    check_eq("ramp_up_reached_play", seen, 1);
    check_eq("ramp_up_monotonic_bad", mono_bad, 0);
    check_eq("ramp_up_play_edge", e, win_after(n) * 256 - 1 + 127 * 256 * RDIV + 1);

    tick(8'h90, n);
    expect_duty(n, 8'h90);
    wait_windows(3);
    enable = 1'b0;
    @(negedge CLK);
    check_eq("ramp_down_playing", playing, 0);
    check_eq("ramp_down_amp_on", amp_sd_n, 1);
    wait_windows(5);
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 * 256 && !seen; i++) begin
      @(negedge CLK);
      if (playing) seen = 1;
    end
    check_eq("reversed_ramp_play", seen, 1);

    tick(8'h10, n);
    expect_duty(n, 8'h10);
    wait_windows(3);
    n = edge_cnt;
    enable = 1'b0;
    seen = 0;
    e = 0;
    for (int i = 0; i < 30 * 256 && !seen; i++) begin
      @(negedge CLK);
      if (!amp_sd_n) begin
        seen = 1;
        e = edge_cnt - 1;
      end
    end
    check_eq("ramp_down_reached_off", seen, 1);
    check_eq("off_playing", playing, 0);
    check_eq("ramp_down_time_ok", (e - n >= 15 * 256) && (e - n <= 18 * 256), 1);
    check_eq("scoreboard_drained", sb.size(), 0);

    enable = 1'b1;
    wait_windows(3);
`else
    tick(8'h55, n);
    n = edge_cnt;
    enable = 1'b1;
    @(negedge CLK);
    check_eq("play_next_cycle", playing, 1);
    check_eq("amp_on_next_cycle", amp_sd_n, 1);
    expect_duty(n, 8'h55);
    wait_windows(3);
    tick(8'hC0, n);
    expect_duty(n, 192);
    wait_windows(3);
    tick(8'h00, n);
    expect_duty(n, 0);
    wait_windows(3);
    tick(8'hFF, n);
    expect_duty(n, 255);
    last = n;

    seen = 0;
    e = 0;
    for (int i = 0; i < WD + 300 && !seen; i++) begin
      @(negedge CLK);
      if (underrun) begin
        seen = 1;
        e = edge_cnt - 1;
      end
    end
    check_eq("underrun_seen", seen, 1);
    if (!seen) e = edge_cnt;
    check_eq("underrun_delay", e - last, WD);
    expect_duty(e, 128);
    @(negedge CLK);
    check_eq("underrun_single_cycle", underrun, 0);

    while (edge_cnt < e + WD) @(negedge CLK);
    tick(8'h33, n);
    pulses = underrun;
    repeat (50) begin
      @(negedge CLK);
      pulses += underrun;
    end
    check_eq("tick_on_expiry_pulses", pulses, 0);
    expect_duty(n, 8'h33);

    for (int i = 0; i < 1000 && sb.size() > 0; i++) @(negedge CLK);
    check_eq("scoreboard_drained", sb.size(), 0);

    enable = 1'b0;
    @(negedge CLK);
    check_eq("off_playing", playing, 0);
    check_eq("off_amp_sd_n", amp_sd_n, 0);
    repeat (300) @(negedge CLK);
    bad = 0;
    repeat (256) begin
      @(negedge CLK);
      if (pwm_out) bad++;
    end
    check_eq("off_period_high_cycles", bad, 0);

    enable = 1'b1;
    @(negedge CLK);
    check_eq("replay_playing", playing, 1);
    tick(8'hA0, n);
`endif

    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge CLK);
      if (pwm_out) seen = 1;
    end
    check_eq("pwm_high_before_reset", seen, 1);
    mon_en = 1'b0;
    #1;
    RESET_N = 1'b0;
    #1;
    check_eq("async_reset_pwm_out", pwm_out, 0);
    check_eq("async_reset_playing", playing, 0);
    check_eq("async_reset_amp_sd_n", amp_sd_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : timeout
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
